// File: rtl/npc_pkg.sv
// Shared constants and types for the instruction fetch stage.
package npc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        VALID,
        EXEC,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/ifu_npc_gen.sv
// Combinational next-PC adder: (imm | 4) + (rs1 | pc), bit0 cleared for jalr, bit1 flags misalignment.
module ifu_npc_gen
    import npc_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] imm_i,
    input  logic        pca_src_i,
    input  logic        pcb_src_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] add_a;
    logic [31:0] add_b;

    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        add_a      = pca_src_i ? imm_i : PC_STEP;
        add_b      = pcb_src_i ? rs1_i : pc_i;
        next_pc_o  = add_a + add_b;
        if (pcb_src_i) begin
            next_pc_o[0] = 1'b0;
        end
        misalign_o = next_pc_o[1];
    end

endmodule

// File: rtl/ifu_mem_fetch.sv
// Multi-cycle fetch stage: one outstanding memory request per instruction, IDU handshake, PC commit on retire.
// Optional perf counters are enabled with `define IFU_PERF_CNT_EN.
module ifu_mem_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PERF_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WBU_finish,
    input  logic              PCAsrc,
    input  logic              PCBsrc,
    input  logic [31:0]       rs1,
    input  logic [31:0]       imm,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              IFU_valid,
    input  logic              IDU_ready,
    output logic [31:0]       inst,
    output logic [31:0]       pc,
    output logic              fetch_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         req_valid_q;
    logic         rsp_ready_q;
    logic         ifu_valid_q;
    logic         fault_q;

    logic [31:0]  next_pc;
    logic         npc_misalign;

    ifu_npc_gen u_npc_gen (
        .pc_i       (pc_q),
        .rs1_i      (rs1),
        .imm_i      (imm),
        .pca_src_i  (PCAsrc),
        .pcb_src_i  (PCBsrc),
        .next_pc_o  (next_pc),
        .misalign_o (npc_misalign)
    );

    // Handshake outputs are registered alongside the state, so REQ right after reset
    // spends one cycle raising mem_req_valid before a request can be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            ifu_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                REQ: begin
                    if (req_valid_q && mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= WAIT;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (mem_rsp_err) begin
                            fault_q <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            inst_q      <= mem_rsp_data;
                            ifu_valid_q <= 1'b1;
                            state_q     <= VALID;
                        end
                    end
                end
                VALID: begin
                    if (IDU_ready) begin
                        ifu_valid_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (WBU_finish) begin
                        if (npc_misalign) begin
                            fault_q <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q        <= next_pc;
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                end
                HALT: begin
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b0;
                    ifu_valid_q <= 1'b0;
                end
                default: begin
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b0;
                    ifu_valid_q <= 1'b0;
                    fault_q     <= 1'b1;
                    state_q     <= HALT;
                end
            endcase
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = pc_q;
    assign mem_rsp_ready = rsp_ready_q;
    assign IFU_valid     = ifu_valid_q;
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign fetch_fault   = fault_q;

`ifdef IFU_PERF_CNT_EN
    logic [PERF_W-1:0] fetch_cnt_q;
    logic [PERF_W-1:0] fetch_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;
    logic              req_stall;
    logic              rsp_stall;

    always_comb begin
        req_stall   = req_valid_q && !mem_req_ready;
        rsp_stall   = rsp_ready_q && !mem_rsp_valid;
        fetch_cnt_d = fetch_cnt_q + PERF_W'(ifu_valid_q && IDU_ready);
        stall_cnt_d = stall_cnt_q + PERF_W'(req_stall || rsp_stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    a_perf_w_legal: assert property (@(posedge clk) PERF_W > 0);

    a_finish_only_in_exec: assert property (
        @(posedge clk) disable iff (rst) WBU_finish |-> (state_q == EXEC)
    );

    a_rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) mem_rsp_valid |-> (state_q == WAIT)
    );
`endif

endmodule
